// File: rtl/instr_pack.sv
// Shared definitions for the 9-bit CPU: sequencer states, error codes and
// the subroutine entry-address table used by jtsr.
package instr_pack;

    localparam int SR_ENTRIES = 16;
    localparam int SR_ADDR_W  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        ERR  = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_OVERFLOW  = 2'd1,
        ERR_UNDERFLOW = 2'd2
    } seq_err_t;

    // Entries 1..15 are placeholders until their subroutines are assigned.
    localparam logic [SR_ADDR_W-1:0] SR_TABLE [SR_ENTRIES] = '{
        10'd100, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0,
        10'd0,   10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0
    };

endpackage

// File: rtl/return_stack.sv
// Small LIFO holding subroutine return addresses. The pointer counts 0..DEPTH;
// dout always shows the top entry, which is only meaningful when not empty.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      ptr;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full    = (ptr == (AW+1)'(DEPTH));
    assign empty   = (ptr == '0);
    assign top_idx = ptr[AW-1:0] - AW'(1);
    assign dout    = mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (push && !full) begin
            ptr <= ptr + (AW+1)'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - (AW+1)'(1);
        end
    end

    // Contents need no reset: the pointer alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: registered pc with a one-edge next-pc mux for
// branch, call, return and halt, plus a hardware return stack for nesting.
module pc_sequencer
    import instr_pack::*;
#(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic            br_take,
    input  logic [7:0]      br_target,
    input  logic            jsr,
    input  logic [3:0]      jsr_idx,
    input  logic            rts,
    input  logic            halt_req,
    output logic [PC_W-1:0] pc,
    output logic            running,
    output logic            done,
    output logic            err,
    output logic [1:0]      err_code
);

    seq_state_t      state;
    seq_err_t        err_q;
    logic            rs_push;
    logic            rs_pop;
    logic            rs_clear;
    logic            rs_full;
    logic            rs_empty;
    logic [PC_W-1:0] rs_top;
    logic [PC_W-1:0] pc_inc;
    logic            active;

    assign pc_inc   = pc + PC_W'(1);
    assign err_code = err_q;

    // A cycle where a control-flow request can actually take effect.
    assign active   = (state == RUN) && !stall && !halt_req;
    assign rs_pop   = active && rts && !rs_empty;
    assign rs_push  = active && !rts && jsr && !rs_full;
    assign rs_clear = start && ((state == HALT) || (state == ERR));

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_return_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (rs_clear),
        .push  (rs_push),
        .pop   (rs_pop),
        .din   (pc_inc),
        .dout  (rs_top),
        .full  (rs_full),
        .empty (rs_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            err_q   <= ERR_NONE;
            running <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT, ERR: begin
                    if (start) begin
                        state   <= RUN;
                        pc      <= '0;
                        err_q   <= ERR_NONE;
                        running <= 1'b1;
                        done    <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                RUN: begin
                    if (stall) begin
                        pc <= pc;
                    end else if (halt_req) begin
                        state   <= HALT;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (rts) begin
                        if (rs_empty) begin
                            state   <= ERR;
                            err_q   <= ERR_UNDERFLOW;
                            running <= 1'b0;
                            err     <= 1'b1;
                        end else begin
                            pc <= rs_top;
                        end
                    end else if (jsr) begin
                        // Overflow leaves pc on the faulting call.
                        if (rs_full) begin
                            state   <= ERR;
                            err_q   <= ERR_OVERFLOW;
                            running <= 1'b0;
                            err     <= 1'b1;
                        end else begin
                            pc <= PC_W'(SR_TABLE[jsr_idx]);
                        end
                    end else if (br_take) begin
                        pc <= PC_W'(br_target);
                    end else begin
                        pc <= pc_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: inputs change just after the falling edge,
// outputs are checked on the following falling edge.
module tb_pc_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stall;
    logic       br_take;
    logic [7:0] br_target;
    logic       jsr;
    logic [3:0] jsr_idx;
    logic       rts;
    logic       halt_req;
    logic [9:0] pc;
    logic       running;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    int n_tests = 0;
    int n_fail  = 0;

    pc_sequencer #(
        .PC_W        (10),
        .STACK_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stall     (stall),
        .br_take   (br_take),
        .br_target (br_target),
        .jsr       (jsr),
        .jsr_idx   (jsr_idx),
        .rts       (rts),
        .halt_req  (halt_req),
        .pc        (pc),
        .running   (running),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; br_take = 0; br_target = 0;
        jsr = 0; jsr_idx = 0; rts = 0; halt_req = 0;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic branch_to(input logic [7:0] t);
        br_take = 1; br_target = t; tick(); br_take = 0; br_target = 0;
    endtask

    task automatic call(input logic [3:0] idx);
        jsr = 1; jsr_idx = idx; tick(); jsr = 0; jsr_idx = 0;
    endtask

    task automatic ret();
        rts = 1; tick(); rts = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        tick(); tick();
        n_tests++;
        if (pc !== 10'd0 || running !== 0 || done !== 0 || err !== 0 || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: pc=%0d run=%0b done=%0b err=%0b code=%0d expected 0/0/0/0/0",
                     pc, running, done, err, err_code);
        end
        rst_n = 1;
        tick();
        n_tests++;
        if (pc !== 10'd0 || running !== 0) begin
            n_fail++;
            $display("FAIL idle_hold: pc=%0d run=%0b expected 0/0", pc, running);
        end
    endtask

    task automatic test_sequential();
        pulse_start();
        n_tests++;
        if (pc !== 10'd0 || running !== 1) begin
            n_fail++;
            $display("FAIL start: pc=%0d run=%0b expected 0/1", pc, running);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_tests++;
            if (pc !== 10'(i) || running !== 1) begin
                n_fail++;
                $display("FAIL seq_step%0d: pc=%0d run=%0b expected %0d/1", i, pc, running, i);
            end
        end
    endtask

    task automatic test_branch();
        branch_to(8'd96);
        n_tests++;
        if (pc !== 10'd96) begin
            n_fail++;
            $display("FAIL branch_96: pc=%0d expected 96", pc);
        end
        branch_to(8'd9);
        n_tests++;
        if (pc !== 10'd9) begin
            n_fail++;
            $display("FAIL branch_taken: pc=%0d expected 9", pc);
        end
        branch_to(8'd96);
        br_take = 0; br_target = 8'd9;
        tick();
        br_target = 0;
        n_tests++;
        if (pc !== 10'd97) begin
            n_fail++;
            $display("FAIL branch_not_taken: pc=%0d expected 97", pc);
        end
        branch_to(8'd255);
        repeat (768) tick();
        n_tests++;
        if (pc !== 10'd1023) begin
            n_fail++;
            $display("FAIL reach_1023: pc=%0d expected 1023", pc);
        end
        tick();
        n_tests++;
        if (pc !== 10'd0) begin
            n_fail++;
            $display("FAIL wrap: pc=%0d expected 0", pc);
        end
    endtask

    task automatic test_call_return();
        branch_to(8'd45);
        call(4'd0);
        n_tests++;
        if (pc !== 10'd100) begin
            n_fail++;
            $display("FAIL jsr_target: pc=%0d expected 100", pc);
        end
        repeat (12) tick();
        ret();
        n_tests++;
        if (pc !== 10'd46 || running !== 1) begin
            n_fail++;
            $display("FAIL rts_return: pc=%0d run=%0b expected 46/1", pc, running);
        end
        ret();
        n_tests++;
        if (err !== 1 || err_code !== 2'd2 || pc !== 10'd46 || running !== 0) begin
            n_fail++;
            $display("FAIL underflow: err=%0b code=%0d pc=%0d run=%0b expected 1/2/46/0",
                     err, err_code, pc, running);
        end
    endtask

    task automatic test_overflow();
        pulse_start();
        n_tests++;
        if (pc !== 10'd0 || err !== 0 || err_code !== 2'd0 || running !== 1) begin
            n_fail++;
            $display("FAIL restart_from_err: pc=%0d err=%0b code=%0d run=%0b expected 0/0/0/1",
                     pc, err, err_code, running);
        end
        call(4'd5);
        n_tests++;
        if (pc !== 10'd0) begin
            n_fail++;
            $display("FAIL jsr_idx5: pc=%0d expected 0", pc);
        end
        for (int i = 0; i < 3; i++) call(4'd0);
        n_tests++;
        if (pc !== 10'd100 || err !== 0) begin
            n_fail++;
            $display("FAIL fourth_call: pc=%0d err=%0b expected 100/0", pc, err);
        end
        call(4'd0);
        n_tests++;
        if (err !== 1 || err_code !== 2'd1 || pc !== 10'd100) begin
            n_fail++;
            $display("FAIL overflow: err=%0b code=%0d pc=%0d expected 1/1/100", err, err_code, pc);
        end
        branch_to(8'd7);
        n_tests++;
        if (pc !== 10'd100) begin
            n_fail++;
            $display("FAIL err_holds_pc: pc=%0d expected 100", pc);
        end
        pulse_start();
        ret();
        n_tests++;
        if (err_code !== 2'd2 || pc !== 10'd0) begin
            n_fail++;
            $display("FAIL start_empties_stack: code=%0d pc=%0d expected 2/0", err_code, pc);
        end
    endtask

    task automatic test_halt_priority();
        pulse_start();
        tick(); tick();
        halt_req = 1; jsr = 1; jsr_idx = 0;
        tick();
        halt_req = 0; jsr = 0;
        n_tests++;
        if (done !== 1 || running !== 0 || pc !== 10'd2) begin
            n_fail++;
            $display("FAIL halt_priority: done=%0b run=%0b pc=%0d expected 1/0/2", done, running, pc);
        end
        call(4'd0);
        n_tests++;
        if (pc !== 10'd2 || done !== 1) begin
            n_fail++;
            $display("FAIL halt_ignores_ctrl: pc=%0d done=%0b expected 2/1", pc, done);
        end
        pulse_start();
        n_tests++;
        if (pc !== 10'd0 || running !== 1 || done !== 0) begin
            n_fail++;
            $display("FAIL restart_from_halt: pc=%0d run=%0b done=%0b expected 0/1/0", pc, running, done);
        end
        ret();
        n_tests++;
        if (err_code !== 2'd2) begin
            n_fail++;
            $display("FAIL halt_no_push: code=%0d expected 2", err_code);
        end
    endtask

    task automatic test_stall();
        pulse_start();
        branch_to(8'd20);
        stall = 1; br_take = 1; br_target = 8'd50;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (pc !== 10'd20) begin
                n_fail++;
                $display("FAIL stall_hold%0d: pc=%0d expected 20", i, pc);
            end
        end
        stall = 0;
        tick();
        br_take = 0; br_target = 0;
        n_tests++;
        if (pc !== 10'd50) begin
            n_fail++;
            $display("FAIL stall_release: pc=%0d expected 50", pc);
        end
    endtask

    task automatic test_reset_mid_call();
        call(4'd0);
        n_tests++;
        if (pc !== 10'd100) begin
            n_fail++;
            $display("FAIL midcall_setup: pc=%0d expected 100", pc);
        end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if (pc !== 10'd0 || running !== 0 || done !== 0 || err !== 0) begin
            n_fail++;
            $display("FAIL async_reset: pc=%0d run=%0b done=%0b err=%0b expected 0/0/0/0",
                     pc, running, done, err);
        end
        tick();
        rst_n = 1;
        tick();
        pulse_start();
        ret();
        n_tests++;
        if (err_code !== 2'd2 || err !== 1) begin
            n_fail++;
            $display("FAIL reset_clears_stack: code=%0d err=%0b expected 2/1", err_code, err);
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        tick();
        test_reset();
        test_sequential();
        test_branch();
        test_call_return();
        test_overflow();
        test_halt_priority();
        test_stall();
        test_reset_mid_call();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
